// File: rtl/qqspi_arbiter.sv
// qqspi_arbiter: shares one qqspi controller between instruction fetch (port 0)
// and load/store (port 1). The winning request is registered onto the mem_*
// bus, held until the controller answers, and the answer is returned to the
// granted port as a one-cycle ready pulse.
module qqspi_arbiter #(
  parameter int ADDR_W    = 23,
  parameter bit RR_MODE   = 1'b1,
  parameter bit FAIR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,

  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,

  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,

  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state;
  logic        rr_ptr;   // port that wins the next tie in round-robin mode
  logic [31:0] rdata;
  logic        win;

  // Pick the port to serve from the current requesters (only used in IDLE)
  always_comb begin
    win = 1'b0;
    if (m0_valid && m1_valid)
      win = RR_MODE ? rr_ptr : 1'b0;
    else
      win = !m0_valid;
  end

  // Arbiter FSM: IDLE -> REQ (hold request) -> DRAIN (wait for controller idle)
  always_ff @(posedge clk) begin
    m0_ready <= 1'b0;
    m1_ready <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata     <= '0;
      grant     <= FAIR_INIT;
      rr_ptr    <= FAIR_INIT;
    end else begin
      case (state)
        IDLE: begin
          // A lingering mem_ready means the controller is not yet idle
          if (!mem_ready && (m0_valid || m1_valid)) begin
            mem_addr  <= win ? m1_addr  : m0_addr;
            mem_wdata <= win ? m1_wdata : m0_wdata;
            mem_wstrb <= win ? m1_wstrb : m0_wstrb;
            grant     <= win;
            mem_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            rdata     <= mem_rdata;
            if (grant) m1_ready <= 1'b1;
            else       m0_ready <= 1'b1;
            mem_valid <= 1'b0;
            if (RR_MODE) rr_ptr <= ~grant;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Bench for qqspi_arbiter: two arbiters (round-robin and fixed-priority), each
// with its own requesters and controller model. A per-unit monitor predicts
// grants and responses from the arbitration rules and scores them.
module tb_qqspi_arbiter;
  localparam int AW = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          v0[2], v1[2], r0[2], r1[2], mv[2], mr[2], busy[2], grant[2];
  logic [AW-1:0] a0[2], a1[2], ma[2];
  logic [31:0]   w0[2], w1[2], rd0[2], rd1[2], mw[2], mrd[2];
  logic [3:0]    s0[2], s1[2], ms[2];

  // controller model knobs
  int          lat_fixed[2]   = '{0, 0};
  int          lat_max[2]     = '{4, 4};
  int          drain_fixed[2] = '{0, 0};
  int          drain_max[2]   = '{2, 2};
  bit          use_data_fixed[2] = '{0, 0};
  logic [31:0] data_fixed[2]  = '{32'h0, 32'h0};

  // reference model state
  logic [31:0] expq[2][$];
  int          glog[2][$];
  logic        ptr[2];
  logic        cur_win[2];
  int          rise_cyc[2] = '{-10, -10};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int u, input int p);
    if (p == 0) v0[u] = 1'b0; else v1[u] = 1'b0;
  endtask

  // One requester transaction; returns at the negedge where ready is seen
  task automatic do_tx(input int u, input int p, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int gap,
                       output logic [31:0] rd);
    int n;
    if (gap > 0) begin
      idle(u, p);
      repeat (gap) @(negedge clk);
    end
    if (p == 0) begin v0[u] = 1'b1; a0[u] = a; w0[u] = d; s0[u] = s; end
    else        begin v1[u] = 1'b1; a1[u] = a; w1[u] = d; s1[u] = s; end
    n = 0;
    rd = 32'h0;
    forever begin
      @(negedge clk);
      if ((p == 0) ? r0[u] : r1[u]) begin
        rd = (p == 0) ? rd0[u] : rd1[u];
        break;
      end
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL timeout: unit %0d port %0d no ready within 400 cycles", u, p);
        break;
      end
    end
  endtask

  task automatic rand_port(input int u, input int p, input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++)
      do_tx(u, p, AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), rd);
    idle(u, p);
  endtask

  for (genvar u = 0; u < 2; u++) begin : g_unit
    localparam bit RR   = (u == 0);
    localparam bit FAIR = (u != 0);

    logic          s_v0, s_v1, s_mr, s_rst;
    logic [AW-1:0] s_a0, s_a1, h_a;
    logic [31:0]   s_w0, s_w1, h_w;
    logic [3:0]    s_s0, s_s1, h_s;

    qqspi_arbiter #(.ADDR_W(AW), .RR_MODE(RR), .FAIR_INIT(FAIR)) dut (
      .clk(clk), .reset(rst),
      .m0_valid(v0[u]), .m0_addr(a0[u]), .m0_wdata(w0[u]), .m0_wstrb(s0[u]),
      .m0_ready(r0[u]), .m0_rdata(rd0[u]),
      .m1_valid(v1[u]), .m1_addr(a1[u]), .m1_wdata(w1[u]), .m1_wstrb(s1[u]),
      .m1_ready(r1[u]), .m1_rdata(rd1[u]),
      .mem_valid(mv[u]), .mem_addr(ma[u]), .mem_wdata(mw[u]), .mem_wstrb(ms[u]),
      .mem_ready(mr[u]), .mem_rdata(mrd[u]),
      .grant(grant[u]), .busy(busy[u]));

    // inputs exactly as the DUT samples them
    always @(posedge clk) begin
      s_v0 <= v0[u]; s_a0 <= a0[u]; s_w0 <= w0[u]; s_s0 <= s0[u];
      s_v1 <= v1[u]; s_a1 <= a1[u]; s_w1 <= w1[u]; s_s1 <= s1[u];
      s_mr <= mr[u]; s_rst <= rst;
    end

    // controller model: answer after a latency, hold ready until valid drops (+hold)
    initial begin
      int cnt, hold;
      cnt = -1; hold = 0; mr[u] = 1'b0; mrd[u] = 32'h0;
      forever begin
        @(negedge clk);
        if (mr[u]) begin
          if (!mv[u]) begin
            if (hold == 0) mr[u] = 1'b0;
            else hold--;
          end
        end else if (mv[u]) begin
          if (cnt < 0) cnt = (lat_fixed[u] > 0) ? lat_fixed[u] : int'($urandom_range(1, lat_max[u]));
          cnt--;
          if (cnt == 0) begin
            cnt = -1;
            mr[u] = 1'b1;
            mrd[u] = use_data_fixed[u] ? data_fixed[u] : $urandom;
            hold = (drain_fixed[u] >= 0) ? drain_fixed[u] : int'($urandom_range(0, drain_max[u]));
            rise_cyc[u] = cyc;
            expq[u].push_back(mrd[u]);
          end
        end else begin
          cnt = -1;
        end
      end
    end

    // monitor / scoreboard
    initial begin
      logic        prev_mv, prev_busy, exp_rise, act_rise, win;
      logic [31:0] d;
      prev_mv = 1'b0; prev_busy = 1'b1;
      forever begin
        @(negedge clk);
        if (s_rst) begin
          chk("rst_mem_valid", mv[u], 1'b0);
          chk("rst_no_ready", {r1[u], r0[u]}, 2'b00);
          chk("rst_grant", grant[u], FAIR);
          expq[u].delete();
          ptr[u] = FAIR;
          rise_cyc[u] = -10;
        end else begin
          exp_rise = !prev_busy && !s_mr && (s_v0 || s_v1);
          act_rise = mv[u] && !prev_mv;
          if (exp_rise || act_rise) chk("grant_timing", act_rise, exp_rise);
          if (act_rise) begin
            if (s_v0 && s_v1) win = RR ? ptr[u] : 1'b0;
            else              win = !s_v0;
            cur_win[u] = win;
            glog[u].push_back(int'(win));
            h_a = win ? s_a1 : s_a0;
            h_w = win ? s_w1 : s_w0;
            h_s = win ? s_s1 : s_s0;
            chk("grant", grant[u], win);
            chk("mem_payload", {ma[u], mw[u], ms[u]}, {h_a, h_w, h_s});
          end else if (mv[u]) begin
            chk("req_stable", {grant[u], ma[u], mw[u], ms[u]}, {cur_win[u], h_a, h_w, h_s});
          end
          if (s_mr) chk("busy_drain", busy[u], 1'b1);
          if (r0[u] || r1[u]) begin
            chk("ready_port", {r1[u], r0[u]}, cur_win[u] ? 2'b10 : 2'b01);
            chk("ready_latency", cyc - rise_cyc[u], 1);
            if (expq[u].size() == 0) begin
              checks++; errors++;
              $display("FAIL ready_spurious: unit %0d ready with no pending response", u);
            end else begin
              d = expq[u].pop_front();
              chk("rdata", {rd1[u], rd0[u]}, {d, d});
            end
            if (RR) ptr[u] = !cur_win[u];
          end else if (cyc == rise_cyc[u] + 1) begin
            checks++; errors++;
            $display("FAIL ready_missing: unit %0d no ready 1 cycle after mem_ready", u);
          end
        end
        prev_mv = mv[u];
        prev_busy = busy[u];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n0, t0;
    bit seen;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      v0[u] = 0; a0[u] = 0; w0[u] = 0; s0[u] = 0;
      v1[u] = 0; a1[u] = 0; w1[u] = 0; s1[u] = 0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_mem_addr", ma[u], 0);
      chk("rst_mem_wdata", mw[u], 0);
      chk("rst_mem_wstrb", ms[u], 0);
      chk("rst_rdata", {rd1[u], rd0[u]}, 0);
      chk("rst_busy", busy[u], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests, round-robin: 0,1,0,1...
    lat_fixed[0] = 3;
    n0 = glog[0].size();
    fork
      begin logic [31:0] r; for (int i = 0; i < 4; i++) do_tx(0, 0, AW'($urandom), $urandom, 4'h0, 0, r); idle(0, 0); end
      begin logic [31:0] r; for (int i = 0; i < 4; i++) do_tx(0, 1, AW'($urandom), $urandom, 4'h0, 0, r); idle(0, 1); end
    join
    chk("rr_count", glog[0].size() - n0, 8);
    for (int i = 0; i < 8 && n0 + i < glog[0].size(); i++) chk("rr_alternate", glog[0][n0 + i], i % 2);

    // single port-0 read with a slow controller
    lat_fixed[0] = 40; use_data_fixed[0] = 1; data_fixed[0] = 32'hDEADBEEF;
    do_tx(0, 0, 23'h000010, 32'h0, 4'h0, 1, rd);
    idle(0, 0);
    chk("p0_read_rdata", rd, 32'hDEADBEEF);
    use_data_fixed[0] = 0;

    // fixed priority: port 1 starves while port 0 keeps requesting
    lat_fixed[1] = 2;
    n0 = glog[1].size();
    fork
      begin logic [31:0] r; for (int i = 0; i < 6; i++) do_tx(1, 0, AW'($urandom), $urandom, 4'h0, 0, r); idle(1, 0); end
      begin logic [31:0] r; do_tx(1, 1, AW'($urandom), $urandom, 4'h0, 0, r); idle(1, 1); end
    join
    chk("fp_count", glog[1].size() - n0, 7);
    for (int i = 0; i < 7 && n0 + i < glog[1].size(); i++) chk("fp_order", glog[1][n0 + i], (i == 6) ? 1 : 0);

    // port 1 write, controller holds ready 5 cycles, port 0 waits out DRAIN
    lat_fixed[0] = 3; drain_fixed[0] = 5;
    fork
      begin logic [31:0] r; do_tx(0, 1, 23'h200004, 32'h12345678, 4'b0011, 1, r); idle(0, 1); end
      begin
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = r1[0]; end
        t0 = cyc;
        fork
          begin logic [31:0] r; do_tx(0, 0, 23'h000040, 32'h0, 4'h0, 0, r); idle(0, 0); end
          begin
            int k;
            k = 0;
            do begin @(negedge clk); k++; end while (!mv[0] && k < 400);
            chk("drain_spacing", cyc - t0, 7);
          end
        join
      end
    join
    drain_fixed[0] = 0;

    // reset in the middle of REQ abandons the transaction; it is reissued after
    lat_fixed[0] = 20;
    fork
      begin logic [31:0] r; do_tx(0, 1, 23'h0ABCDE, $urandom, 4'h0, 1, r); idle(0, 1); end
      begin
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreq_mem_valid", mv[0], 1'b0);
        chk("midreq_busy", busy[0], 1'b0);
        chk("midreq_grant", grant[0], 1'b0);
        chk("midreq_no_ready", r1[0], 1'b0);
      end
    join

    // randomized traffic on both arbiters
    for (int u = 0; u < 2; u++) begin
      lat_fixed[u] = 0; lat_max[u] = 6; drain_fixed[u] = -1; drain_max[u] = 3;
    end
    fork
      rand_port(0, 0, 80);
      rand_port(0, 1, 80);
      rand_port(1, 0, 80);
      rand_port(1, 1, 80);
    join

    repeat (20) @(negedge clk);
    for (int u = 0; u < 2; u++) chk("scoreboard_empty", expq[u].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qqspi_arbiter.md
Name: qqspi_arbiter

Overview:
- Two-port arbiter that shares one qqspi memory controller between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Registers the winning request and drives the controller's valid/ready handshake.
- Returns read data and a one-cycle ready pulse to the granted port.
- Sits between the CPU bus split and the qqspi instance. Both requesters use the same valid/ready/addr/wdata/wstrb convention as the controller.

Parameters:
ADDR_W, 23, request address width (8Mx32 word space; top 2 bits select chip)
RR_MODE, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins
FAIR_INIT, 0, port that wins the first tie after reset in round-robin mode

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
m0_valid  in  1  port 0 request; held until m0_ready
m0_addr  in  ADDR_W  port 0 word address
m0_wdata  in  32  port 0 write data
m0_wstrb  in  4  port 0 byte strobes; 0 = read
m0_ready  out  1  port 0 completion pulse
m0_rdata  out  32  port 0 read data, valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  as port 0, for port 1
mem_valid  out  1  request to qqspi
mem_addr  out  ADDR_W  registered address to qqspi
mem_wdata  out  32  registered write data
mem_wstrb  out  4  registered strobes
mem_ready  in  1  qqspi done; stays high until mem_valid drops
mem_rdata  in  32  qqspi read data, valid while mem_ready=1
grant  out  1  port currently or last served (0/1)
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- state=IDLE, mem_valid=0, mem_addr/mem_wdata=0, mem_wstrb=0.
- m0_ready=m1_ready=0, rdata register=0, grant=FAIR_INIT, rr pointer=FAIR_INIT.
- Reset mid-transaction abandons it: mem_valid drops next edge and no ready pulse is issued.

State IDLE:
- Enter arbitration only if mem_ready=0 and (m0_valid | m1_valid).
- Winner selection:
  - RR_MODE=0: port 0 if m0_valid, else port 1.
  - RR_MODE=1: single requester wins; if both request, the port not served last (rr pointer) wins.
- On a win: latch the winner's addr/wdata/wstrb into mem_* registers, set grant, assert mem_valid, go to REQ (all at the next edge).

State REQ:
- mem_valid=1; mem_* held stable; requester inputs ignored.
- On mem_ready=1:
  - capture mem_rdata into the rdata register;
  - pulse m{grant}_ready=1 for exactly one cycle;
  - clear mem_valid;
  - in round-robin mode, set rr pointer to the other port;
  - go to DRAIN.

State DRAIN:
- mem_valid=0. Stay while mem_ready=1; go to IDLE when mem_ready=0.
- Guarantees the controller has returned to idle before the next request.

Outputs and timing:
- m0_rdata and m1_rdata both drive the rdata register; they are meaningful only with the matching ready pulse.
- Latency from requester valid (sampled in IDLE) to mem_valid: 1 cycle.
- Latency from mem_ready to requester ready: 1 cycle.
- Minimum spacing between grants = DRAIN duration + 1 cycle.

Requester contract:
- valid is held with stable payload until ready.
- valid high on the cycle after the ready pulse is a new transaction. The arbiter never samples it before IDLE, so there is no double-issue.
- A requester dropping valid before ready is a protocol violation; the transaction still completes and its ready pulse is still issued.

Write handling:
- The arbiter does not interpret wstrb; writes and reads are treated identically.
- Write completion pulses ready and rdata is don't-care.

Simultaneous events:
- A new request arriving in the same cycle as mem_ready is not granted until IDLE.
- Both ports requesting in the same IDLE cycle: exactly one is granted, and the other waits with valid held.

Test Plan:
- Port 0 read only, addr=0x000010, mem_ready after 40 cycles with mem_rdata=0xDEADBEEF -> mem_valid 1 cycle after m0_valid; m0_ready one-cycle pulse with m0_rdata=0xDEADBEEF; m1_ready never asserts.
- Both ports assert valid in the same cycle, RR_MODE=1, FAIR_INIT=0 -> port 0 served first, then port 1. Repeat with both held: grants alternate 0,1,0,1 for 8 transactions.
- RR_MODE=0, both ports continuously requesting -> port 0 granted every time and port 1 starves. Drop m0_valid -> port 1 granted next IDLE.
- Port 1 write addr=0x200004, wdata=0x12345678, wstrb=0b0011 -> mem_addr/wdata/wstrb equal inputs and stay stable throughout REQ; single m1_ready pulse; mem_valid low until mem_ready low.
- mem_ready held high for 5 cycles after mem_valid drops -> arbiter stays in DRAIN with busy=1. A pending m0_valid is not granted until the cycle after mem_ready falls.
- reset asserted while in REQ -> next edge mem_valid=0, no ready pulse, grant=FAIR_INIT. A request after reset release is served normally.
